// File: rtl/frogger_game_ctrl.sv
// Frogger game controller: lives, score and level bookkeeping plus the
// respawn / play / dying / win / game-over sequencing with timed states.
module frogger_game_ctrl #(
    parameter int c_LIVES        = 3,
    parameter int c_GOAL_ROW     = 0,
    parameter int c_DEATH_CYCLES = 25_000_000,
    parameter int c_WIN_CYCLES   = 12_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic [2:0] o_State,
    output logic [1:0] o_Lives,
    output logic [7:0] o_Score,
    output logic [2:0] o_Level,
    output logic       o_Respawn,
    output logic       o_Move_En,
    output logic       o_Game_Over
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESPAWN   = 3'd1,
        PLAY      = 3'd2,
        DYING     = 3'd3,
        WIN       = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [24:0] DEATH_LOAD = 25'(c_DEATH_CYCLES - 1);
    localparam logic [24:0] WIN_LOAD   = 25'(c_WIN_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(c_LIVES);
    localparam logic [5:0]  GOAL_ROW   = 6'(c_GOAL_ROW);

    state_t      state;
    logic [24:0] count;
    logic        blocked;   // first PLAY cycle: frog position still reloading

    assign o_State = state;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            count       <= '0;
            blocked     <= 1'b0;
            o_Lives     <= LIVES_INIT;
            o_Score     <= '0;
            o_Level     <= '0;
            o_Respawn   <= 1'b0;
            o_Move_En   <= 1'b0;
            o_Game_Over <= 1'b0;
        end else begin
            o_Respawn <= 1'b0;
            case (state)
                IDLE: begin
                    o_Move_En   <= 1'b0;
                    o_Game_Over <= 1'b0;
                    if (i_Start) begin
                        state     <= RESPAWN;
                        o_Respawn <= 1'b1;
                        o_Lives   <= LIVES_INIT;
                        o_Score   <= '0;
                        o_Level   <= '0;
                    end
                end
                RESPAWN: begin
                    state     <= PLAY;
                    o_Move_En <= 1'b1;
                    blocked   <= 1'b1;
                end
                PLAY: begin
                    blocked <= 1'b0;
                    if (!blocked) begin
                        // collision wins over reaching the goal row
                        if (i_Collided) begin
                            state     <= DYING;
                            o_Move_En <= 1'b0;
                            count     <= DEATH_LOAD;
                            if (o_Lives != 2'd0)
                                o_Lives <= o_Lives - 2'd1;
                        end else if (i_Frogger_Y == GOAL_ROW) begin
                            state     <= WIN;
                            o_Move_En <= 1'b0;
                            count     <= WIN_LOAD;
                            if (o_Score != 8'hFF)
                                o_Score <= o_Score + 8'd1;
                            if (o_Level != 3'd7)
                                o_Level <= o_Level + 3'd1;
                        end
                    end
                end
                DYING: begin
                    if (count == '0) begin
                        if (o_Lives == 2'd0) begin
                            state       <= GAME_OVER;
                            o_Game_Over <= 1'b1;
                        end else begin
                            state     <= RESPAWN;
                            o_Respawn <= 1'b1;
                        end
                    end else begin
                        count <= count - 25'd1;
                    end
                end
                WIN: begin
                    if (count == '0) begin
                        state     <= RESPAWN;
                        o_Respawn <= 1'b1;
                    end else begin
                        count <= count - 25'd1;
                    end
                end
                GAME_OVER: begin
                    o_Lives <= 2'd0;
                    if (i_Start) begin
                        state       <= RESPAWN;
                        o_Respawn   <= 1'b1;
                        o_Game_Over <= 1'b0;
                        o_Lives     <= LIVES_INIT;
                        o_Score     <= '0;
                        o_Level     <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_Move_En   <= 1'b0;
                    o_Game_Over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frogger_game_ctrl.md
FROGGER_GAME_CTRL -- requirements
Module: frogger_game_ctrl

Interface
REQ-001 Parameter c_LIVES, default 3: lives granted at game start, range 1-3.
REQ-002 Parameter c_GOAL_ROW, default 0: frog Y row that counts as reaching home.
REQ-003 Parameter c_DEATH_CYCLES, default 25_000_000: DYING state duration in clocks, range 1 to 2^25-1.
REQ-004 Parameter c_WIN_CYCLES, default 12_500_000: WIN state duration in clocks, range 1 to 2^25-1.
REQ-005 i_Clk  in  1  single clock for all logic.
REQ-006 i_Rst_L  in  1  reset, synchronous, active-low.
REQ-007 i_Start  in  1  start-game request, level-sampled each clock.
REQ-008 i_Collided  in  1  collision flag from the collision detector, level.
REQ-009 i_Frogger_Y  in  6  current frog row.
REQ-010 o_State  out  3  FSM state: IDLE=0, RESPAWN=1, PLAY=2, DYING=3, WIN=4, GAME_OVER=5.
REQ-011 o_Lives  out  2  remaining lives.
REQ-012 o_Score  out  8  frogs delivered home, binary.
REQ-013 o_Level  out  3  difficulty level, drives car/log speed configuration.
REQ-014 o_Respawn  out  1  one-cycle pulse; frog module reloads its original X/Y.
REQ-015 o_Move_En  out  1  frog movement enable.
REQ-016 o_Game_Over  out  1  high while in GAME_OVER.

Function
REQ-017 All outputs SHALL be registered; state changes one clock after the qualifying input is sampled.
REQ-018 IDLE: o_Move_En=0; i_Start=1 -> RESPAWN, loading o_Lives=c_LIVES, o_Score=0, o_Level=0 on the same edge.
REQ-019 RESPAWN: o_Respawn=1 for exactly one cycle; next state SHALL be PLAY unconditionally.
REQ-020 PLAY: o_Move_En=1; i_Collided=1 -> DYING with o_Lives decremented by 1 on the same edge.
REQ-021 PLAY: i_Collided=0 and i_Frogger_Y==c_GOAL_ROW -> WIN with o_Score+1 and o_Level+1 on the same edge.
REQ-022 Simultaneous collision and goal row in PLAY SHALL be treated as collision only; score and level unchanged.
REQ-023 o_Score SHALL saturate at 255; o_Level SHALL saturate at 7; o_Lives SHALL never decrement below 0.
REQ-024 i_Collided SHALL be ignored in every state except PLAY.
REQ-025 Collision and goal detection in PLAY SHALL be blocked during the first PLAY cycle after RESPAWN, allowing the frog position to reload.
REQ-026 DYING: o_Move_En=0; a 25-bit down-counter SHALL load c_DEATH_CYCLES-1 on entry; at count 0 -> GAME_OVER if o_Lives==0, else RESPAWN.
REQ-027 WIN: o_Move_En=0; the counter SHALL load c_WIN_CYCLES-1 on entry; at count 0 -> RESPAWN.
REQ-028 A state entered with duration N SHALL be occupied for exactly N clocks.
REQ-029 GAME_OVER: o_Game_Over=1, o_Move_En=0; o_Lives=0, and o_Score and o_Level SHALL be held; i_Start=1 -> RESPAWN with the reinitialisation defined in REQ-018.
REQ-030 i_Start SHALL be ignored in RESPAWN, PLAY, DYING and WIN.
REQ-031 Unused state encodings 6 and 7 SHALL transition to IDLE on the next clock.

Reset
REQ-032 While i_Rst_L=0 at a rising i_Clk edge: state IDLE, o_Lives=c_LIVES, o_Score=0, o_Level=0, counter=0, o_Respawn=0, o_Move_En=0, o_Game_Over=0.
REQ-033 Reset SHALL override every state mid-operation, including during a DYING/WIN countdown, with no residual o_Respawn pulse.

Verification (c_DEATH_CYCLES=4, c_WIN_CYCLES=2, c_LIVES=3, c_GOAL_ROW=0)
REQ-034 Reset, then i_Start for 1 cycle -> o_State 0->1->2, o_Respawn high exactly 1 cycle, o_Lives=3, o_Move_En=1 in PLAY.
REQ-035 In PLAY, pulse i_Collided -> o_State=3 for 4 clocks, o_Lives=2, then RESPAWN pulse, then PLAY.
REQ-036 Three collisions -> after the third DYING, o_State=5, o_Game_Over=1, o_Lives=0; i_Start -> o_Lives=3, o_Score=0.
REQ-037 i_Frogger_Y=0 in PLAY (after the blocked cycle) -> WIN for 2 clocks, o_Score=1, o_Level=1; eight wins -> o_Level stays 7.
REQ-038 i_Collided=1 with i_Frogger_Y=0 on the same cycle -> DYING, o_Score unchanged; i_Collided held high in DYING causes no extra decrement.
REQ-039 i_Rst_L=0 on the 2nd DYING cycle -> next state IDLE, o_Lives=3, o_Respawn=0.
